fetch_queue: RTL and testbench

Instruction-granular, parametrised fetch queue between the I-cache return path and Decode. It accepts up to FETCH_WIDTH instructions per packet with a per-lane valid mask, compacts them, and stores each instruction with its own PC. It presents up to PIPE_WIDTH in-order instructions per cycle, and Decode may consume any prefix of 0..PIPE_WIDTH of them. Partial packets, mid-packet redirect targets and partial decode consumption all need no bubble.

---
 rtl/uarch_pkg.sv | 21 ++
 rtl/fetch_queue_if.sv | 38 +++
 rtl/fetch_queue_lane_compactor.sv | 27 ++
 rtl/fetch_queue.sv | 185 ++++++++++++++++++
 tb/tb_fetch_queue.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/uarch_pkg.sv
// Shared micro-architecture package: front-end widths, queue depth and the
// per-instruction entry type carried from fetch to decode.
package uarch_pkg;

   localparam int FETCH_WIDTH    = 2;
   localparam int PIPE_WIDTH     = 2;
   localparam int INST_BUF_DEPTH = 8;
   localparam int ADDR_BITS      = 32;
   localparam int INST_BITS      = 32;
   localparam int PC_STEP        = 4;

   typedef struct packed {
      logic [ADDR_BITS-1:0] pc;
      logic [INST_BITS-1:0] inst;
   } fetch_entry_t;

   function automatic int min_int(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-queue port bundle: enqueue packet from the I-cache return path,
// dequeue slots towards Decode, synchronous flush and occupancy.
interface fetch_queue_if #(
   parameter int FETCH_WIDTH = uarch_pkg::FETCH_WIDTH,
   parameter int PIPE_WIDTH  = uarch_pkg::PIPE_WIDTH,
   parameter int DEPTH       = uarch_pkg::INST_BUF_DEPTH,
   parameter int ADDR_BITS   = uarch_pkg::ADDR_BITS,
   parameter int INST_BITS   = uarch_pkg::INST_BITS
);

   localparam int TAKE_BITS  = $clog2(PIPE_WIDTH + 1);
   localparam int COUNT_BITS = $clog2(DEPTH + 1);

   logic                                  flush;
   logic                                  enq_val;
   logic                                  enq_rdy;
   logic [ADDR_BITS-1:0]                  enq_pc;
   logic [FETCH_WIDTH-1:0]                enq_mask;
   logic [FETCH_WIDTH-1:0][INST_BITS-1:0] enq_insts;
   logic [PIPE_WIDTH-1:0]                 deq_val;
   logic [PIPE_WIDTH-1:0][ADDR_BITS-1:0]  deq_pc;
   logic [PIPE_WIDTH-1:0][INST_BITS-1:0]  deq_inst;
   logic [TAKE_BITS-1:0]                  deq_take;
   logic [COUNT_BITS-1:0]                 count;

   // Fetch/decode side driving the queue.
   modport master (
      output flush, enq_val, enq_pc, enq_mask, enq_insts, deq_take,
      input  enq_rdy, deq_val, deq_pc, deq_inst, count
   );

   // The queue itself.
   modport slave (
      input  flush, enq_val, enq_pc, enq_mask, enq_insts, deq_take,
      output enq_rdy, deq_val, deq_pc, deq_inst, count
   );

endinterface

// File: rtl/fetch_queue_lane_compactor.sv
// Lane compactor: turns a per-lane valid mask into the destination offset
// of each lane (exclusive prefix sum) and the number of valid lanes.
module lane_compactor #(
   parameter int FETCH_WIDTH = uarch_pkg::FETCH_WIDTH
) (
   input  logic [FETCH_WIDTH-1:0]                            mask,
   output logic [FETCH_WIDTH-1:0][$clog2(FETCH_WIDTH+1)-1:0] offset,
   output logic [$clog2(FETCH_WIDTH+1)-1:0]                  popcount
);

   localparam int OFF_W = $clog2(FETCH_WIDTH + 1);

   logic [FETCH_WIDTH:0][OFF_W-1:0] running;

   // Exclusive prefix sum over the mask; the final term is the popcount.
   always_comb begin
      // NOTE: every output of a combinational block gets a value on every
      // path, otherwise synthesis infers a latch to hold the old one.
      running[0] = '0;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         offset[i]    = running[i];
         running[i+1] = running[i] + OFF_W'(mask[i]);
      end
      popcount = running[FETCH_WIDTH];
   end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-granular fetch queue between the I-cache return path and
// Decode. Packets are compacted lane by lane into a circular buffer of
// {pc, inst} entries; Decode sees up to PIPE_WIDTH in-order slots and may
// consume any prefix of them.
// Optional feature: FETCH_QUEUE_BYPASS_EN -- when the queue is empty an
// enqueuing packet is presented to Decode in the same cycle.
module fetch_queue #(
   parameter int FETCH_WIDTH = uarch_pkg::FETCH_WIDTH,
   parameter int PIPE_WIDTH  = uarch_pkg::PIPE_WIDTH,
   parameter int DEPTH       = uarch_pkg::INST_BUF_DEPTH
) (
   input logic          clk,
   input logic          rst,
   fetch_queue_if.slave fq
);

   import uarch_pkg::*;

   localparam int IDX_W  = $clog2(DEPTH);
   localparam int PTR_W  = IDX_W + 1;
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int TAKE_W = $clog2(PIPE_WIDTH + 1);
   localparam int OFF_W  = $clog2(FETCH_WIDTH + 1);

   fetch_entry_t mem [DEPTH];

   logic [PTR_W-1:0]                   head;
   logic [PTR_W-1:0]                   tail;
   logic [CNT_W-1:0]                   cnt;

   logic [FETCH_WIDTH-1:0][OFF_W-1:0]  lane_off;
   logic [OFF_W-1:0]                   lane_pop;
   fetch_entry_t                       lane_entry [FETCH_WIDTH];

   logic                               rdy;
   logic                               fire;
   logic                               bypass;
   logic [OFF_W-1:0]                   enq_pop;
   logic [TAKE_W-1:0]                  avail;
   logic [TAKE_W-1:0]                  take;
   logic [TAKE_W-1:0]                  skip;
   fetch_entry_t                       slot_entry [PIPE_WIDTH];

   logic [FETCH_WIDTH-1:0]             wr_en;
   logic [IDX_W-1:0]                   wr_idx [FETCH_WIDTH];

   lane_compactor #(
      .FETCH_WIDTH (FETCH_WIDTH)
   ) u_lane_compactor (
      .mask     (fq.enq_mask),
      .offset   (lane_off),
      .popcount (lane_pop)
   );

   // Admission: space is judged on the registered count only, so a full
   // packet is refused even when its mask is sparse.
   assign rdy     = (DEPTH - int'(cnt) >= FETCH_WIDTH) && !fq.flush;
   assign fire    = fq.enq_val && rdy;
   assign enq_pop = fire ? lane_pop : '0;

   assign fq.enq_rdy = rdy;
   assign fq.count   = cnt;

   // Attach the sequential PC to every lane of the incoming packet.
   always_comb begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         lane_entry[i].pc   = fq.enq_pc + ADDR_BITS'(PC_STEP * i);
         lane_entry[i].inst = fq.enq_insts[i];
      end
   end

`ifdef FETCH_QUEUE_BYPASS_EN
   fetch_entry_t comp_entry [PIPE_WIDTH];

   // An enqueue into an empty queue is forwarded straight to Decode.
   assign bypass = fire && (cnt == '0);

   // Compacted view of the incoming packet, one entry per Decode slot.
   always_comb begin
      for (int k = 0; k < PIPE_WIDTH; k++) begin
         comp_entry[k] = '0;
         for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (fq.enq_mask[i] && int'(lane_off[i]) == k) begin
               comp_entry[k] = lane_entry[i];
            end
         end
      end
   end

   // Slots presented this cycle: the packet itself when bypassing, else storage.
   always_comb begin
      for (int j = 0; j < PIPE_WIDTH; j++) begin
         slot_entry[j] = bypass ? comp_entry[j] : mem[head[IDX_W-1:0] + IDX_W'(j)];
      end
   end

   // Number of visible slots, forced to zero while flushing.
   always_comb begin
      if (fq.flush) begin
         avail = '0;
      end else if (bypass) begin
         avail = TAKE_W'(min_int(int'(lane_pop), PIPE_WIDTH));
      end else begin
         avail = TAKE_W'(min_int(int'(cnt), PIPE_WIDTH));
      end
   end

   // Lanes consumed by Decode through the bypass are never written.
   assign skip = bypass ? take : '0;
`else
   assign bypass = 1'b0;
   assign skip   = '0;

   // Slots presented this cycle come from storage at head+j.
   always_comb begin
      for (int j = 0; j < PIPE_WIDTH; j++) begin
         slot_entry[j] = mem[head[IDX_W-1:0] + IDX_W'(j)];
      end
   end

   // Number of visible slots, forced to zero while flushing.
   always_comb begin
      if (fq.flush) begin
         avail = '0;
      end else begin
         avail = TAKE_W'(min_int(int'(cnt), PIPE_WIDTH));
      end
   end
`endif

   // Clamp an over-large deq_take to the slots actually shown.
   assign take = (fq.deq_take > avail) ? avail : fq.deq_take;

   // Drive the thermometer-valid slots; invalid slots read as zero.
   always_comb begin
      for (int j = 0; j < PIPE_WIDTH; j++) begin
         fq.deq_val[j]  = int'(avail) > j;
         fq.deq_pc[j]   = '0;
         fq.deq_inst[j] = '0;
         if (int'(avail) > j) begin
            fq.deq_pc[j]   = slot_entry[j].pc;
            fq.deq_inst[j] = slot_entry[j].inst;
         end
      end
   end

   // Per-lane write enable and compacted destination relative to the tail.
   always_comb begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         wr_en[i]  = fire && fq.enq_mask[i] && (int'(lane_off[i]) >= int'(skip));
         wr_idx[i] = IDX_W'(int'(tail[IDX_W-1:0]) + int'(lane_off[i]) - int'(skip));
      end
   end

   // Entry storage write port.
   // NOTE: the storage array has no reset; head/tail/count alone define
   // which entries are live, so stale contents are never observed.
   always_ff @(posedge clk) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         if (wr_en[i]) begin
            mem[wr_idx[i]] <= lane_entry[i];
         end
      end
   end

   // Head, tail and occupancy; flush wins over enqueue and dequeue.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (rst) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else if (fq.flush) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else begin
         head <= head + PTR_W'(take) - PTR_W'(skip);
         tail <= tail + PTR_W'(enq_pop) - PTR_W'(skip);
         cnt  <= cnt + CNT_W'(enq_pop) - CNT_W'(take);
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a scoreboard of {pc, inst} entries
// is filled as packets are accepted and drained as Decode consumes slots.
// Also covers FETCH_QUEUE_BYPASS_EN when that macro is defined.
module tb_fetch_queue;

   import uarch_pkg::*;

   localparam int DEPTH_T = 8;
   localparam int FW      = 2;
   localparam int PW      = 2;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   fetch_queue_if #(
      .FETCH_WIDTH (FW),
      .PIPE_WIDTH  (PW),
      .DEPTH       (DEPTH_T),
      .ADDR_BITS   (ADDR_BITS),
      .INST_BITS   (INST_BITS)
   ) fq ();

   fetch_queue #(
      .FETCH_WIDTH (FW),
      .PIPE_WIDTH  (PW),
      .DEPTH       (DEPTH_T)
   ) dut (
      .clk (clk),
      .rst (rst),
      .fq  (fq)
   );

   int           n_vec = 0;
   int           n_err = 0;
   fetch_entry_t sb [$];
   logic [31:0]  next_pc;
   logic [31:0]  inst_seq;
   bit           last_fire;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock of stimulus; outputs are checked against the model at negedge.
   task automatic cycle(input logic val, input logic [31:0] pc, input logic [1:0] mask,
                        input logic [31:0] i0, input logic [31:0] i1,
                        input logic [1:0] take, input logic fl);
      fetch_entry_t lanes [$];
      fetch_entry_t e;
      bit           exp_rdy;
      bit           fire;
      bit           pushed;
      int           avail;
      int           take_eff;
      logic [1:0]   therm;
      @(posedge clk);
      #1;
      fq.enq_val      = val;
      fq.enq_pc       = pc;
      fq.enq_mask     = mask;
      fq.enq_insts[0] = i0;
      fq.enq_insts[1] = i1;
      fq.deq_take     = take;
      fq.flush        = fl;
      exp_rdy = (DEPTH_T - sb.size() >= FW) && !fl;
      fire    = val && exp_rdy;
      for (int i = 0; i < FW; i++) begin
         if (mask[i]) begin
            e.pc   = pc + 32'(4 * i);
            e.inst = (i == 0) ? i0 : i1;
            lanes.push_back(e);
         end
      end
      @(negedge clk);
      check("count", 64'(fq.count), 64'(sb.size()));
      check("enq_rdy", 64'(fq.enq_rdy), 64'(exp_rdy));
      pushed = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
      if (fire && sb.size() == 0) begin
         foreach (lanes[k]) sb.push_back(lanes[k]);
         pushed = 1'b1;
      end
`endif
      avail = fl ? 0 : min_int(sb.size(), PW);
      therm = (avail == 0) ? 2'b00 : (avail == 1) ? 2'b01 : 2'b11;
      check("deq_val", 64'(fq.deq_val), 64'(therm));
      for (int j = 0; j < PW; j++) begin
         check($sformatf("deq_pc%0d", j), 64'(fq.deq_pc[j]), (j < avail) ? 64'(sb[j].pc) : 64'd0);
         check($sformatf("deq_inst%0d", j), 64'(fq.deq_inst[j]), (j < avail) ? 64'(sb[j].inst) : 64'd0);
      end
      take_eff = min_int(int'(take), avail);
      if (fl) begin
         sb.delete();
      end else begin
         repeat (take_eff) void'(sb.pop_front());
         if (fire && !pushed) foreach (lanes[k]) sb.push_back(lanes[k]);
      end
      last_fire = fire;
   endtask

   // Sequential-PC packet with fresh instruction words.
   task automatic pkt(input logic val, input logic [1:0] mask, input logic [1:0] take, input logic fl);
      cycle(val, next_pc, mask, inst_seq, inst_seq + 32'd1, take, fl);
      if (last_fire) begin
         next_pc  = next_pc + 32'd8;
         inst_seq = inst_seq + 32'd2;
      end
   endtask

   task automatic idle(input logic [1:0] take);
      cycle(1'b0, 32'h0, 2'b00, 32'h0, 32'h0, take, 1'b0);
   endtask

   task automatic drain();
      for (int i = 0; i < 6; i++) idle(2'd2);
   endtask

   logic [31:0] exp_head_pc;

   initial begin
      rst         = 1'b1;
      fq.flush    = 1'b0;
      fq.enq_val  = 1'b0;
      fq.enq_pc   = '0;
      fq.enq_mask = '0;
      fq.enq_insts = '0;
      fq.deq_take = '0;
      next_pc     = 32'h0000_1000;
      inst_seq    = 32'hC0DE_0000;
      #12 rst = 1'b0;

      // Reset state with idle inputs.
      idle(2'd0);
      idle(2'd0);
      check("rst_count", 64'(fq.count), 64'd0);
      check("rst_rdy", 64'(fq.enq_rdy), 64'd1);

      // Sparse mask: only lane 1 is kept, at pc+4.
      cycle(1'b1, 32'h100, 2'b10, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 2'd0, 1'b0);
      idle(2'd0);
      check("sparse_val", 64'(fq.deq_val), 64'b01);
      check("sparse_pc", 64'(fq.deq_pc[0]), 64'h104);
      check("sparse_inst", 64'(fq.deq_inst[0]), 64'hBBBB_BBBB);
      check("sparse_count", 64'(fq.count), 64'd1);
      drain();

      // Fill to full, then a fifth packet must be refused.
      exp_head_pc = next_pc;
      for (int i = 0; i < 4; i++) pkt(1'b1, 2'b11, 2'd0, 1'b0);
      pkt(1'b1, 2'b11, 2'd0, 1'b0);
      check("full_count", 64'(fq.count), 64'd8);
      check("full_rdy", 64'(fq.enq_rdy), 64'd0);
      check("full_pc0", 64'(fq.deq_pc[0]), 64'(exp_head_pc));
      check("full_pc1", 64'(fq.deq_pc[1]), 64'(exp_head_pc + 32'd4));
      idle(2'd0);
      check("full_hold", 64'(fq.count), 64'd8);
      drain();

      // Partial take with wrap: PCs at the head must stay strictly sequential.
      exp_head_pc = next_pc;
      pkt(1'b1, 2'b11, 2'd0, 1'b0);
      pkt(1'b1, 2'b01, 2'd0, 1'b0);
      next_pc = exp_head_pc + 32'd12;
      for (int i = 0; i < 12; i++) begin
         pkt(1'b1, 2'b11, 2'd1, 1'b0);
         check("wrap_seq_pc", 64'(fq.deq_pc[0]), 64'(exp_head_pc));
         exp_head_pc = exp_head_pc + 32'd4;
      end
      drain();

      // Simultaneous enqueue and dequeue at count 6.
      for (int i = 0; i < 3; i++) pkt(1'b1, 2'b11, 2'd0, 1'b0);
      pkt(1'b1, 2'b11, 2'd2, 1'b0);
      idle(2'd0);
      check("simul_count", 64'(fq.count), 64'd6);
      check("simul_rdy", 64'(fq.enq_rdy), 64'd1);

      // Flush conflicting with enqueue and dequeue.
      pkt(1'b1, 2'b11, 2'd2, 1'b1);
      check("flush_val", 64'(fq.deq_val), 64'd0);
      check("flush_rdy", 64'(fq.enq_rdy), 64'd0);
      idle(2'd0);
      check("flush_count", 64'(fq.count), 64'd0);

      // Over-large deq_take is clamped to the visible slots.
      pkt(1'b1, 2'b01, 2'd0, 1'b0);
      idle(2'd3);
      idle(2'd0);
      check("clamp_count", 64'(fq.count), 64'd0);

`ifdef FETCH_QUEUE_BYPASS_EN
      // Same-cycle bypass into an empty queue, with one lane consumed.
      cycle(1'b1, 32'h300, 2'b11, 32'hAAAA_0001, 32'hBBBB_0002, 2'd1, 1'b0);
      check("byp_inst0", 64'(fq.deq_inst[0]), 64'hAAAA_0001);
      idle(2'd0);
      check("byp_count", 64'(fq.count), 64'd1);
      check("byp_head", 64'(fq.deq_inst[0]), 64'hBBBB_0002);
      drain();
`endif

      // Random traffic with occasional flush and over-large takes.
      for (int i = 0; i < 300; i++) begin
         cycle(($urandom % 4) != 0, $urandom, 2'($urandom_range(0, 3)),
               $urandom, $urandom, 2'($urandom_range(0, 3)), ($urandom % 25) == 0);
      end

      // Asynchronous reset in the middle of operation.
      for (int i = 0; i < 3; i++) pkt(1'b1, 2'b11, 2'd0, 1'b0);
      @(posedge clk);
      #2;
      fq.enq_val = 1'b0;
      rst = 1'b1;
      #1;
      check("arst_count", 64'(fq.count), 64'd0);
      check("arst_val", 64'(fq.deq_val), 64'd0);
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      idle(2'd0);
      idle(2'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
